pkt_data_buffer: RTL and testbench

PKT_DATA_BUFFER -- requirements
Module: pkt_data_buffer

---
 rtl/pkt_data_buffer_if.sv | 49 ++++
 rtl/pkt_data_buffer.sv | 169 ++++++++++++++++
 tb/tb_pkt_data_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_data_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_data_buffer_if
//  Brief    : Bus bundle between the AHB side, the USB side and the packet
//             data buffer. The master drives strobes and data. The slave
//             (the buffer) returns read data, occupancy and status.
//  Revision : 1.0  initial release
// ============================================================================
interface pkt_data_buffer_if #(
    parameter int DEPTH = 64
) ();
    localparam int AW = $clog2(DEPTH);

    // Flush
    logic            clear;
    // AHB side
    logic [31:0]     tx_data;
    logic            store_tx_data;
    logic            get_rx_data;
    logic [1:0]      data_size;
    logic [31:0]     rx_data;
    // USB side
    logic [7:0]      rx_packet_data;
    logic            store_rx_packet_data;
    logic            get_tx_packet_data;
    logic [7:0]      tx_packet_data;
    // Status
    logic [AW:0]     buffer_occupancy;
    logic            empty;
    logic            full;
    logic            overflow;
    logic            underflow;
    logic            collision;

    modport master (
        output clear, tx_data, store_tx_data, get_rx_data, data_size,
               rx_packet_data, store_rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, empty, full,
               overflow, underflow, collision
    );

    modport slave (
        input  clear, tx_data, store_tx_data, get_rx_data, data_size,
               rx_packet_data, store_rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, empty, full,
               overflow, underflow, collision
    );
endinterface
`default_nettype wire

// File: rtl/pkt_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_data_buffer
//  Brief    : Byte-wide circular buffer shared by an AHB port (1/2/4-byte
//             words, little-endian) and a USB port (single bytes). It also
//             reports occupancy, full/empty and one-cycle error pulses.
//  Revision : 1.0  initial release
// ============================================================================
module pkt_data_buffer #(
    parameter int DEPTH = 64            // power of two, 8..1024
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pkt_data_buffer_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic [31:0]   r_rx_data;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_collision;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [2:0]    w_size_n;
    logic          w_wr_ahb;
    logic          w_rd_ahb;
    logic          w_wr_req;
    logic          w_rd_req;
    logic [2:0]    w_nw;
    logic [2:0]    w_nr;
    logic [AW:0]   w_nw_ext;
    logic [AW:0]   w_nr_ext;
    logic [AW:0]   w_free;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [AW:0]   w_occ_next;
    logic [AW-1:0] w_waddr [4];
    logic [AW-1:0] w_raddr [4];
    logic [7:0]    w_wbyte [4];
    logic [31:0]   w_rd_word;

    // Decode the AHB transfer size into a byte count (size 3 behaves as 4)
    always_comb begin
        case (bus.data_size)
            2'd0:    w_size_n = 3'd1;
            2'd1:    w_size_n = 3'd2;
            default: w_size_n = 3'd4;
        endcase
    end

    // Arbitrate each side (AHB wins) and decide acceptance of the whole
    // transfer against occupancy as it stood at the start of the cycle
    always_comb begin
        w_wr_ahb = bus.store_tx_data;
        w_rd_ahb = bus.get_rx_data;
        w_wr_req = bus.store_tx_data | bus.store_rx_packet_data;
        w_rd_req = bus.get_rx_data   | bus.get_tx_packet_data;
        w_nw     = w_wr_ahb ? w_size_n : (bus.store_rx_packet_data ? 3'd1 : 3'd0);
        w_nr     = w_rd_ahb ? w_size_n : (bus.get_tx_packet_data   ? 3'd1 : 3'd0);
        w_nw_ext = {{(AW-2){1'b0}}, w_nw};
        w_nr_ext = {{(AW-2){1'b0}}, w_nr};
        w_free   = c_DEPTH - r_occ;
        // Clear overrides everything, so nothing is accepted in that cycle
        w_wr_ok  = w_wr_req && !bus.clear && (w_nw_ext <= w_free);
        w_rd_ok  = w_rd_req && !bus.clear && (w_nr_ext <= r_occ);
        w_occ_next = r_occ + (w_wr_ok ? w_nw_ext : '0) - (w_rd_ok ? w_nr_ext : '0);
    end

    // Per-lane wrapped addresses and write bytes for up to four lanes
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_waddr[k] = r_wr_ptr + AW'(k);
            w_raddr[k] = r_rd_ptr + AW'(k);
            w_wbyte[k] = w_wr_ahb ? bus.tx_data[8*k +: 8] : bus.rx_packet_data;
        end
    end

    // Gather the read word. Unused upper lanes are zero. Data comes from
    // the pre-edge memory, so bytes written this cycle are never returned.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_nr) begin
                w_rd_word[8*k +: 8] = r_mem[w_raddr[k]];
            end
        end
    end

    // Byte storage. It is not reset, so contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_nw) begin
                    r_mem[w_waddr[k]] <= w_wbyte[k];
                end
            end
        end
    end

    // Pointers and occupancy. Clear flushes them; accepted ops advance them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(w_nw);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(w_nr);
            end
            r_occ <= w_occ_next;
        end
    end

    // AHB read register: loads only on an accepted AHB read, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data <= '0;
        end else if (w_rd_ok && w_rd_ahb) begin
            r_rx_data <= w_rd_word;
        end
    end

    // One-cycle error pulses. A flush cycle never reports an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_collision <= 1'b0;
        end else if (bus.clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_overflow  <= w_wr_req && !w_wr_ok;
            r_underflow <= w_rd_req && !w_rd_ok;
            r_collision <= (bus.store_tx_data && bus.store_rx_packet_data) ||
                           (bus.get_rx_data   && bus.get_tx_packet_data);
        end
    end

    // Outputs. Full and empty come from occupancy, not from pointer compare.
    assign bus.rx_data          = r_rx_data;
    assign bus.tx_packet_data   = (r_occ == '0) ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.buffer_occupancy = r_occ;
    assign bus.empty            = (r_occ == '0);
    assign bus.full             = (r_occ == c_DEPTH);
    assign bus.overflow         = r_overflow;
    assign bus.underflow        = r_underflow;
    assign bus.collision        = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_pkt_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_data_buffer
//  Brief    : Self-checking bench for pkt_data_buffer (DEPTH=8). It runs a
//             directed vector table, hand-written corner sequences, and
//             random traffic checked against a byte-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pkt_data_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pkt_data_buffer_if #(.DEPTH(DEPTH)) bus ();

    pkt_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model: a plain byte FIFO ----------------
    logic [7:0]  mq [$];
    logic [31:0] m_rx;
    logic        m_ov, m_un, m_col;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rx  = '0;
        m_ov  = 1'b0;
        m_un  = 1'b0;
        m_col = 1'b0;
    endtask

    task automatic model_step();
        int          nw, nr;
        bit          wreq, rreq, wok, rok;
        logic [31:0] w;
        if (bus.clear) begin
            mq.delete();
            m_ov = 1'b0; m_un = 1'b0; m_col = 1'b0;
            return;
        end
        wreq  = bus.store_tx_data || bus.store_rx_packet_data;
        rreq  = bus.get_rx_data   || bus.get_tx_packet_data;
        m_col = (bus.store_tx_data && bus.store_rx_packet_data) ||
                (bus.get_rx_data && bus.get_tx_packet_data);
        nw    = bus.store_tx_data ? nbytes(bus.data_size) : (bus.store_rx_packet_data ? 1 : 0);
        nr    = bus.get_rx_data   ? nbytes(bus.data_size) : (bus.get_tx_packet_data   ? 1 : 0);
        rok   = rreq && (nr <= mq.size());
        wok   = wreq && (nw <= DEPTH - mq.size());
        m_ov  = wreq && !wok;
        m_un  = rreq && !rok;
        // Reads take only bytes present before this cycle's write
        if (rok) begin
            w = '0;
            for (int k = 0; k < nr; k++) w[8*k +: 8] = mq.pop_front();
            if (bus.get_rx_data) m_rx = w;
        end
        if (wok) begin
            for (int k = 0; k < nw; k++)
                mq.push_back(bus.store_tx_data ? bus.tx_data[8*k +: 8] : bus.rx_packet_data);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic clr, input logic [31:0] txd, input logic stx,
                          input logic grx, input logic [1:0] sz, input logic [7:0] rxb,
                          input logic srx, input logic gtx);
        bus.clear                = clr;
        bus.tx_data              = txd;
        bus.store_tx_data        = stx;
        bus.get_rx_data          = grx;
        bus.data_size            = sz;
        bus.rx_packet_data       = rxb;
        bus.store_rx_packet_data = srx;
        bus.get_tx_packet_data   = gtx;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 8'h0, 1'b0, 1'b0);
    endtask

    // Model the edge, take the edge, and sample 1 time unit later
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rx"},    bus.rx_data, m_rx);
        chk({tag, "_txp"},   {24'h0, bus.tx_packet_data}, (mq.size() != 0) ? {24'h0, mq[0]} : 32'h0);
        chk({tag, "_occ"},   32'(bus.buffer_occupancy), 32'(mq.size()));
        chk({tag, "_empty"}, {31'h0, bus.empty}, {31'h0, mq.size() == 0});
        chk({tag, "_full"},  {31'h0, bus.full},  {31'h0, mq.size() == DEPTH});
        chk({tag, "_ovf"},   {31'h0, bus.overflow},  {31'h0, m_ov});
        chk({tag, "_unf"},   {31'h0, bus.underflow}, {31'h0, m_un});
        chk({tag, "_col"},   {31'h0, bus.collision}, {31'h0, m_col});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        clr;
        logic [31:0] txd;
        logic        stx;
        logic        grx;
        logic [1:0]  sz;
        logic [7:0]  rxb;
        logic        srx;
        logic        gtx;
        logic [31:0] e_rx;
        logic [7:0]  e_txp;
        logic [3:0]  e_occ;
        logic        e_ov;
        logic        e_un;
        logic        e_col;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic clr, input logic [31:0] txd, input logic stx,
                                input logic grx, input logic [1:0] sz, input logic [7:0] rxb,
                                input logic srx, input logic gtx, input logic [31:0] e_rx,
                                input logic [7:0] e_txp, input logic [3:0] e_occ,
                                input logic e_ov, input logic e_un, input logic e_col);
        vec_t v;
        v.clr = clr; v.txd = txd; v.stx = stx; v.grx = grx; v.sz = sz; v.rxb = rxb;
        v.srx = srx; v.gtx = gtx; v.e_rx = e_rx; v.e_txp = e_txp; v.e_occ = e_occ;
        v.e_ov = e_ov; v.e_un = e_un; v.e_col = e_col;
        return v;
    endfunction

    initial begin
        //            clr txd           stx grx sz  rxb   srx gtx  e_rx          txp    occ ov un col
        // Packing: one 4-byte word drained byte by byte
        tbl[0]  = mk(0, 32'hDDCCBBAA, 1, 0, 2, 8'h00, 0, 0, 32'h00000000, 8'hAA, 4, 0, 0, 0);
        tbl[1]  = mk(0, 32'h0,        0, 0, 0, 8'h00, 0, 1, 32'h00000000, 8'hBB, 3, 0, 0, 0);
        tbl[2]  = mk(0, 32'h0,        0, 0, 0, 8'h00, 0, 1, 32'h00000000, 8'hCC, 2, 0, 0, 0);
        tbl[3]  = mk(0, 32'h0,        0, 0, 0, 8'h00, 0, 1, 32'h00000000, 8'hDD, 1, 0, 0, 0);
        tbl[4]  = mk(0, 32'h0,        0, 0, 0, 8'h00, 0, 1, 32'h00000000, 8'h00, 0, 0, 0, 0);
        // Unpacking: three USB bytes read as a 2-byte then a 1-byte word
        tbl[5]  = mk(0, 32'h0,        0, 0, 0, 8'h11, 1, 0, 32'h00000000, 8'h11, 1, 0, 0, 0);
        tbl[6]  = mk(0, 32'h0,        0, 0, 0, 8'h22, 1, 0, 32'h00000000, 8'h11, 2, 0, 0, 0);
        tbl[7]  = mk(0, 32'h0,        0, 0, 0, 8'h33, 1, 0, 32'h00000000, 8'h11, 3, 0, 0, 0);
        tbl[8]  = mk(0, 32'h0,        0, 1, 1, 8'h00, 0, 0, 32'h00002211, 8'h33, 1, 0, 0, 0);
        tbl[9]  = mk(0, 32'h0,        0, 1, 0, 8'h00, 0, 0, 32'h00000033, 8'h00, 0, 0, 0, 0);
        // Read from empty: underflow, rx_data holds
        tbl[10] = mk(0, 32'h0,        0, 1, 2, 8'h00, 0, 0, 32'h00000033, 8'h00, 0, 0, 1, 0);
        // Fill to 6, reject a 4-byte write, accept a 2-byte write to full
        tbl[11] = mk(0, 32'h0,        0, 0, 0, 8'h01, 1, 0, 32'h00000033, 8'h01, 1, 0, 0, 0);
        tbl[12] = mk(0, 32'h0,        0, 0, 0, 8'h02, 1, 0, 32'h00000033, 8'h01, 2, 0, 0, 0);
        tbl[13] = mk(0, 32'h0,        0, 0, 0, 8'h03, 1, 0, 32'h00000033, 8'h01, 3, 0, 0, 0);
        tbl[14] = mk(0, 32'h0,        0, 0, 0, 8'h04, 1, 0, 32'h00000033, 8'h01, 4, 0, 0, 0);
        tbl[15] = mk(0, 32'h0,        0, 0, 0, 8'h05, 1, 0, 32'h00000033, 8'h01, 5, 0, 0, 0);
        tbl[16] = mk(0, 32'h0,        0, 0, 0, 8'h06, 1, 0, 32'h00000033, 8'h01, 6, 0, 0, 0);
        tbl[17] = mk(0, 32'hAABBCCDD, 1, 0, 2, 8'h00, 0, 0, 32'h00000033, 8'h01, 6, 1, 0, 0);
        tbl[18] = mk(0, 32'h0000F0E0, 1, 0, 1, 8'h00, 0, 0, 32'h00000033, 8'h01, 8, 0, 0, 0);
        tbl[19] = mk(0, 32'h0,        0, 0, 0, 8'h77, 1, 0, 32'h00000033, 8'h01, 8, 1, 0, 0);
        // Clear with strobes: flush, no pulses, rx_data kept
        tbl[20] = mk(1, 32'h12345678, 1, 1, 2, 8'h00, 0, 1, 32'h00000033, 8'h00, 0, 0, 0, 0);
        // Write collision: AHB word stored, USB byte dropped
        tbl[21] = mk(0, 32'h11223344, 1, 0, 2, 8'h55, 1, 0, 32'h00000033, 8'h44, 4, 0, 0, 1);
        // Read collision: AHB read executes, USB read dropped
        tbl[22] = mk(0, 32'h0,        0, 1, 2, 8'h00, 0, 1, 32'h11223344, 8'h00, 0, 0, 0, 1);
        // Occupancy 3, then a 4-byte read (both sizes 2 and 3) underflows
        tbl[23] = mk(0, 32'h000000A1, 1, 0, 0, 8'h00, 0, 0, 32'h11223344, 8'hA1, 1, 0, 0, 0);
        tbl[24] = mk(0, 32'h0000C3B2, 1, 0, 1, 8'h00, 0, 0, 32'h11223344, 8'hA1, 3, 0, 0, 0);
        tbl[25] = mk(0, 32'h0,        0, 1, 2, 8'h00, 0, 0, 32'h11223344, 8'hA1, 3, 0, 1, 0);
        tbl[26] = mk(0, 32'h0,        0, 1, 3, 8'h00, 0, 0, 32'h11223344, 8'hA1, 3, 0, 1, 0);
        tbl[27] = mk(0, 32'h0,        0, 0, 0, 8'h00, 0, 1, 32'h11223344, 8'hB2, 2, 0, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ",   32'(bus.buffer_occupancy), 32'h0);
        chk("rst_empty", {31'h0, bus.empty}, 32'h1);
        chk("rst_full",  {31'h0, bus.full},  32'h0);
        chk("rst_rx",    bus.rx_data, 32'h0);
        chk("rst_txp",   {24'h0, bus.tx_packet_data}, 32'h0);
        chk("rst_pulse", {29'h0, bus.overflow, bus.underflow, bus.collision}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            set_in(tbl[i].clr, tbl[i].txd, tbl[i].stx, tbl[i].grx, tbl[i].sz,
                   tbl[i].rxb, tbl[i].srx, tbl[i].gtx);
            tick();
            chk($sformatf("v%0d_rx", i),    bus.rx_data, tbl[i].e_rx);
            chk($sformatf("v%0d_txp", i),   {24'h0, bus.tx_packet_data}, {24'h0, tbl[i].e_txp});
            chk($sformatf("v%0d_occ", i),   32'(bus.buffer_occupancy), {28'h0, tbl[i].e_occ});
            chk($sformatf("v%0d_empty", i), {31'h0, bus.empty}, {31'h0, tbl[i].e_occ == 4'd0});
            chk($sformatf("v%0d_full", i),  {31'h0, bus.full},  {31'h0, tbl[i].e_occ == 4'd8});
            chk($sformatf("v%0d_pulse", i), {29'h0, bus.overflow, bus.underflow, bus.collision},
                {29'h0, tbl[i].e_ov, tbl[i].e_un, tbl[i].e_col});
        end

        // Wrap with a simultaneous read: pointers at DEPTH-3, then one byte
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 8'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < DEPTH - 3; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 8'(8'h10 + i), 1'b1, 1'b0);
            tick();
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 8'h0, 1'b0, 1'b1);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 8'h5A, 1'b1, 1'b0);
        tick();
        check_model("wrap_pre");
        // wr_ptr is at DEPTH-2: 4-byte write straddles the wrap while USB pops 5A
        set_in(1'b0, 32'h44332211, 1'b1, 1'b0, 2'd2, 8'h0, 1'b0, 1'b1);
        tick();
        chk("wrap_occ", 32'(bus.buffer_occupancy), 32'd4);
        chk("wrap_txp", {24'h0, bus.tx_packet_data}, 32'h11);
        check_model("wrap_sim");
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 2'd2, 8'h0, 1'b0, 1'b0);
        tick();
        chk("wrap_rd", bus.rx_data, 32'h44332211);
        check_model("wrap_rd");

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            set_in($urandom_range(0, 59) == 0, $urandom,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   2'($urandom_range(0, 3)), 8'($urandom),
                   $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
            tick();
            check_model($sformatf("r%0d", c));
        end

        // Asynchronous reset in the middle of a cycle with a loaded buffer
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 8'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 2'd2, 8'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h01020304, 1'b1, 1'b0, 2'd2, 8'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 2'd0, 8'h0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_occ", 32'(bus.buffer_occupancy), 32'd7);
        chk("pre_rst_rx",  bus.rx_data, 32'h0000000D);
        idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_occ",   32'(bus.buffer_occupancy), 32'h0);
        chk("arst_empty", {31'h0, bus.empty}, 32'h1);
        chk("arst_full",  {31'h0, bus.full},  32'h0);
        chk("arst_rx",    bus.rx_data, 32'h0);
        chk("arst_txp",   {24'h0, bus.tx_packet_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // First edge after reset release takes an operation
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 8'h99, 1'b1, 1'b0);
        tick();
        chk("post_rst_occ", 32'(bus.buffer_occupancy), 32'd1);
        chk("post_rst_txp", {24'h0, bus.tx_packet_data}, 32'h99);
        check_model("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
